// File: rtl/spi_pkg.sv
// Shared SPI definitions.
//   SPI_WORD_W  : bits per SPI word
//   SPI_STATE_W : state encoding width shared with the SPI master FSM
//   rx_state_e  : receiver FSM states (IDLE while cs high, SHIFT while cs low)
package spi_pkg;

  localparam int SPI_WORD_W  = 16;
  localparam int SPI_STATE_W = 2;

  typedef enum logic [SPI_STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } rx_state_e;

endpackage

// File: rtl/spi_slave_rx_if.sv
// Bundle of the SPI receive-side signals.
//   spi_cs / spi_sclk / spi_data : serial lines from the SPI master
//   rx_data / rx_valid / rx_ready : one-deep word output handshake
//   overrun / frame_err           : single-cycle error pulses
//   bit_cnt                       : bits captured in the current word
// Modport master: the side driving the serial lines and rx_ready.
// Modport slave : the receiver itself.
interface spi_slave_rx_if
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_WORD_W
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic                  spi_cs;
  logic                  spi_sclk;
  logic                  spi_data;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  overrun;
  logic                  frame_err;
  logic [CNT_W-1:0]      bit_cnt;

  modport master (
    output spi_cs, spi_sclk, spi_data, rx_ready,
    input  rx_data, rx_valid, overrun, frame_err, bit_cnt
  );

  modport slave (
    input  spi_cs, spi_sclk, spi_data, rx_ready,
    output rx_data, rx_valid, overrun, frame_err, bit_cnt
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with one extra history flop for edge detection.
//   clk, rst : system clock, asynchronous active-high reset
//   d_i      : asynchronous input
//   sync_o   : synchronised level (last chain stage)
//   rise_o   : last stage is 1, history flop is 0
//   fall_o   : last stage is 0, history flop is 1
// RST_VAL sets the idle level so that no spurious edge appears after reset.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              hist_q;

  // Synchroniser chain and history flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= {STAGES{RST_VAL}};
      hist_q  <= RST_VAL;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
      hist_q <= chain_q[STAGES-1];
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = chain_q[STAGES-1] & ~hist_q;
  assign fall_o = ~chain_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI receive deserialiser.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : spi_slave_rx_if.slave
//              in : spi_cs (active low), spi_sclk, spi_data (MSB first), rx_ready
//              out: rx_data, rx_valid, overrun, frame_err, bit_cnt (all registered)
// cs, sclk and data are synchronised through identical chains so they stay
// aligned; bits are captured on synchronised sclk rises while in SHIFT and a
// completed word is offered on a one-deep valid/ready buffer.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_WORD_W,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst,
  spi_slave_rx_if.slave bus
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic cs_sync, cs_rise, cs_fall;
  logic sclk_rise;
  logic data_sync;
  logic sclk_sync_unused, sclk_fall_unused, data_rise_unused, data_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.spi_cs),
    .sync_o (cs_sync),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.spi_sclk),
    .sync_o (sclk_sync_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall_unused)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.spi_data),
    .sync_o (data_sync),
    .rise_o (data_rise_unused),
    .fall_o (data_fall_unused)
  );

  rx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  frame_err_q, frame_err_d;

  logic                  in_shift;
  logic                  capture;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] next_word;

  // A cs rise in the same synced cycle as an sclk rise ends the frame, so
  // that bit is deliberately not captured.
  assign in_shift  = (state_q == SHIFT);
  assign capture   = in_shift & sclk_rise & ~cs_rise & ~cs_sync;
  assign word_done = capture & (bit_cnt_q == LAST_BIT);
  assign next_word = {shift_q[DATA_WIDTH-2:0], data_sync};

  // FSM next state: enter SHIFT on cs fall, leave on cs rise.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cs_fall) state_d = SHIFT;
        else         state_d = IDLE;
      end
      SHIFT: begin
        if (cs_rise) state_d = IDLE;
        else         state_d = SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register, bit counter, output buffer and error pulses next state.
  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;

    if (!in_shift || cs_rise) begin
      // Outside a frame (or leaving it) the partial word is discarded.
      shift_d     = {DATA_WIDTH{1'b0}};
      bit_cnt_d   = CNT_W'(0);
      frame_err_d = in_shift & cs_rise & (bit_cnt_q != CNT_W'(0));
    end else if (capture) begin
      shift_d = next_word;
      if (word_done) bit_cnt_d = CNT_W'(0);
      else           bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end else begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
    end

    // A word completing while the buffer is being popped refills it directly.
    if (word_done) begin
      if (!rx_valid_q || bus.rx_ready) begin
        rx_data_d  = next_word;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= {DATA_WIDTH{1'b0}};
      bit_cnt_q   <= CNT_W'(0);
      rx_data_q   <= {DATA_WIDTH{1'b0}};
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
  assign bus.bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: drives the serial lines at sclk high/low
// of 2 clk cycles each, samples outputs on the falling clk edge and checks
// against hand-computed values.
module tb_spi_slave_rx;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   ovr_cnt = 0;
  int   fe_cnt = 0;
  logic [15:0] popped[$];

  spi_slave_rx_if #(.DATA_WIDTH(16)) bus ();

  spi_slave_rx #(.DATA_WIDTH(16), .SYNC_STAGES(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count error pulses and record every handshake.
  always @(posedge clk) begin
    if (bus.overrun)   ovr_cnt <= ovr_cnt + 1;
    if (bus.frame_err) fe_cnt  <= fe_cnt + 1;
    if (!rst && bus.rx_valid && bus.rx_ready) popped.push_back(bus.rx_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk); bus.spi_sclk = 1'b0; bus.spi_data = b;
    @(negedge clk);
    @(negedge clk); bus.spi_sclk = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[15-i]);
  endtask

  task automatic begin_frame();
    @(negedge clk); bus.spi_cs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk); bus.spi_sclk = 1'b0;
    repeat (2) @(negedge clk);
    bus.spi_cs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk); bus.rx_ready = 1'b1;
    @(negedge clk); bus.rx_ready = 1'b0;
  endtask

  initial begin
    // 1. Reset with random inputs
    rst = 1'b1;
    bus.spi_cs = 1'b1; bus.spi_sclk = 1'b0; bus.spi_data = 1'b0; bus.rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.spi_cs   = 1'($urandom_range(1, 0));
      bus.spi_sclk = 1'($urandom_range(1, 0));
      bus.spi_data = 1'($urandom_range(1, 0));
      bus.rx_ready = 1'($urandom_range(1, 0));
      check("reset_outputs", {bus.rx_valid, bus.overrun, bus.frame_err, bus.bit_cnt, bus.rx_data}, 32'h0);
    end
    @(negedge clk);
    bus.spi_cs = 1'b1; bus.spi_sclk = 1'b0; bus.spi_data = 1'b0; bus.rx_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_reset_idle", {bus.rx_valid, bus.overrun, bus.frame_err, bus.bit_cnt, bus.rx_data}, 32'h0);

    // 2. Single word A5C3, latency and hold
    begin_frame();
    send_bits(16'hA5C3, 16);
    check("a5c3_bitcnt15", bus.bit_cnt, 32'd15);
    check("a5c3_valid_e1", bus.rx_valid, 32'd0);
    @(negedge clk);
    check("a5c3_valid_e2", bus.rx_valid, 32'd0);
    @(negedge clk);
    check("a5c3_valid_e3", bus.rx_valid, 32'd1);
    check("a5c3_data", bus.rx_data, 32'hA5C3);
    check("a5c3_bitcnt_wrap", bus.bit_cnt, 32'd0);
    end_frame();
    check("a5c3_held_valid", bus.rx_valid, 32'd1);
    check("a5c3_held_data", bus.rx_data, 32'hA5C3);
    pop();
    check("a5c3_cleared", bus.rx_valid, 32'd0);
    check("a5c3_pop_count", popped.size(), 32'd1);
    check("a5c3_pop_data", popped[0], 32'hA5C3);

    // 3. Back-to-back words with consumer always ready
    popped.delete();
    bus.rx_ready = 1'b1;
    begin_frame();
    send_bits(16'h1234, 16);
    send_bits(16'hFFFF, 16);
    end_frame();
    bus.rx_ready = 1'b0;
    check("b2b_pop_count", popped.size(), 32'd2);
    check("b2b_first", popped[0], 32'h1234);
    check("b2b_second", popped[1], 32'hFFFF);
    check("b2b_no_overrun", ovr_cnt, 32'd0);
    check("b2b_empty", bus.rx_valid, 32'd0);

    // 4. Overrun, then completion coinciding with a pop
    popped.delete();
    begin_frame();
    send_bits(16'h0001, 16);
    send_bits(16'h8000, 16);
    end_frame();
    check("ovr_count", ovr_cnt, 32'd1);
    check("ovr_valid", bus.rx_valid, 32'd1);
    check("ovr_data_kept", bus.rx_data, 32'h0001);
    begin_frame();
    send_bits(16'h1357, 16);
    @(negedge clk); bus.rx_ready = 1'b1;
    @(negedge clk); bus.rx_ready = 1'b0;
    check("samecyc_valid", bus.rx_valid, 32'd1);
    check("samecyc_data", bus.rx_data, 32'h1357);
    check("samecyc_pop_count", popped.size(), 32'd1);
    check("samecyc_pop_data", popped[0], 32'h0001);
    end_frame();
    check("samecyc_no_overrun", ovr_cnt, 32'd1);
    pop();
    check("samecyc_drained", bus.rx_valid, 32'd0);

    // 5. Framing error after 7 bits, then a clean word
    check("fe_none_yet", fe_cnt, 32'd0);
    begin_frame();
    send_bits(16'hABCD, 7);
    repeat (2) @(negedge clk);
    check("fe_bitcnt7", bus.bit_cnt, 32'd7);
    end_frame();
    check("fe_count", fe_cnt, 32'd1);
    check("fe_no_valid", bus.rx_valid, 32'd0);
    check("fe_bitcnt0", bus.bit_cnt, 32'd0);
    begin_frame();
    send_bits(16'h00FF, 16);
    repeat (2) @(negedge clk);
    check("fe_next_valid", bus.rx_valid, 32'd1);
    check("fe_next_data", bus.rx_data, 32'h00FF);
    end_frame();
    check("fe_legal_rise", fe_cnt, 32'd1);
    pop();

    // 6. Reset mid-word, then BEEF
    begin_frame();
    send_bits(16'h5555, 9);
    repeat (2) @(negedge clk);
    check("rst_bitcnt9", bus.bit_cnt, 32'd9);
    @(negedge clk);
    rst = 1'b1; bus.spi_cs = 1'b1; bus.spi_sclk = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {bus.rx_valid, bus.overrun, bus.frame_err, bus.bit_cnt, bus.rx_data}, 32'h0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_idle", bus.bit_cnt, 32'd0);
    begin_frame();
    send_bits(16'hBEEF, 16);
    repeat (2) @(negedge clk);
    check("beef_valid", bus.rx_valid, 32'd1);
    check("beef_data", bus.rx_data, 32'hBEEF);
    end_frame();
    check("beef_no_fe", fe_cnt, 32'd1);
    pop();
    check("beef_drained", bus.rx_valid, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
